// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush scheduler
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DRAIN_W          = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and async active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - per-cycle stall/flush/halt control for the 5-stage pipeline
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               lu_stall;
  logic               advance;
  logic               active;
  logic               stall_inc;
  logic               flush_inc;

  // A branch squashes the dependent ID instruction, so load_use only stalls without one.
  assign lu_stall  = load_use & ~branch_taken;
  assign advance   = ~mem_busy & ~lu_stall;
  assign active    = (state_q != ST_HALT);
  assign stall_inc = active & (mem_busy | lu_stall);
  assign flush_inc = active & ~mem_busy & branch_taken;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset && active && !mem_busy) begin
      if (branch_taken) begin
        pc_en       = (state_q != ST_DRAIN);
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en       = (state_q != ST_DRAIN);
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = (state_q == ST_DRAIN);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        // A zero count (DRAIN_CYCLES=0) still spends exactly one cycle in DRAIN.
        if (drain_q == '0) begin
          state_d = ST_HALT;
        end else if (advance) begin
          drain_d = drain_q - {{(DRAIN_W-1){1'b0}}, 1'b1};
          if (drain_q == {{(DRAIN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign halted = (state_q == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (stall_inc),
    .count_o (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (flush_inc),
    .count_o (flush_count)
  );

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the load enable and bubble-insert (flush) of every pipeline register bank and the PC register, resolving load-use hazards, taken branches, data-memory wait states and halt/resume requests into one consistent set of controls per cycle. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- CNT_W, 16, width of each performance counter
- DRAIN_CYCLES, 4, number of advancing cycles spent draining the pipeline after a halt request (max 15)

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (low = in reset)
- load_use  in  1  ID instruction depends on a load currently in EX
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  data memory not ready; MEM stage must hold
- halt_req  in  1  request to stop fetching and drain (single-cycle pulse or level)
- resume  in  1  leave HALT and restart fetching
- pc_en  out  1  PC register load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP) instead of data; only meaningful with the matching enable high
- halted  out  1  high in HALT state
- stall_count  out  CNT_W  saturating count of stall/freeze cycles
- flush_count  out  CNT_W  saturating count of branch flushes

## Operation
- States: RUN, DRAIN, HALT. Reset state RUN.
- RUN -> DRAIN when halt_req=1; load drain counter with DRAIN_CYCLES.
- DRAIN -> HALT when drain counter reaches 0. Counter decrements only on cycles that are neither frozen (mem_busy) nor load-use stalled.
- HALT -> RUN when resume=1. resume outside HALT ignored; halt_req outside RUN ignored; halt_req and resume together in HALT: resume wins.
- Control priority per cycle (highest first):
  - reset low: all enables 0, all flushes 0.
  - HALT: all enables 0, flushes 0.
  - mem_busy=1: freeze; all enables 0, flushes 0 (branch_taken/load_use ignored this cycle; upstream re-presents them).
  - branch_taken=1: all enables 1, if_id_flush=1, id_ex_flush=1; pc_en=1 (PC loads target). In DRAIN, pc_en=0.
  - load_use=1: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  - otherwise: all enables 1, flushes 0; in DRAIN additionally pc_en=0 and if_id_flush=1 (bubbles enter ID).
- stall_count +1 on each cycle in RUN or DRAIN with mem_busy=1 or (load_use=1 and branch_taken=0); flush_count +1 on each non-frozen cycle with branch_taken=1. Both saturate at all-ones, never wrap; cleared only by reset.
- halted = (state == HALT).

## Timing
- Enables/flushes are combinational from inputs and current state (same-cycle); no registered latency.
- State, drain counter and performance counters are registered; update on rising clk.
- Reset values: state RUN, drain counter 0, stall_count 0, flush_count 0, halted 0; enables/flushes 0 while reset low.
- Reset asserted mid-DRAIN or HALT: immediate return to RUN on release, counters cleared.
- halted rises the cycle after the last drain decrement (DRAIN_CYCLES advancing cycles after halt_req, plus frozen/stalled cycles).
- DRAIN_CYCLES=0: RUN -> DRAIN -> HALT with one DRAIN cycle.

## Structure
- Package pipeline_ctrl_pkg: state enum (RUN, DRAIN, HALT) and default parameter constants.
- One sub-module: sat_counter (CNT_W-wide, enable input, saturates at max, async active-low clear), instantiated twice for stall_count and flush_count.
- Priority resolution in one combinational block; state/drain counter in one sequential block.

## Test plan
- Reset held low with all inputs 1 -> all enables 0, flushes 0, counters 0; release -> RUN, all enables 1.
- RUN, load_use=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, others 1; stall_count 0->1.
- RUN, branch_taken=1 and load_use=1 together -> branch wins: all en=1, both flushes 1; flush_count +1, stall_count unchanged; same with mem_busy=1 -> all 0, stall_count +1, flush_count unchanged.
- halt_req pulse, DRAIN_CYCLES=4, mem_busy high for 2 cycles in DRAIN -> pc_en=0 throughout, halted rises 7 cycles after pulse (1 RUN->DRAIN, 2 frozen, 4 advancing); halt_req+resume same cycle in HALT -> RUN next cycle.
- CNT_W=4, load_use held 20 cycles -> stall_count saturates at 15 and holds.
- Reset asserted mid-DRAIN -> enables 0 immediately, halted 0, RUN after release.
